// File: rtl/schwap_regfile.sv
// schwap_regfile: banked general register file with window swap by bank select.
//   16 banks x 4 registers x 16 bits. Two combinational read ports and one
//   synchronous write port all address the currently active bank, which is
//   held in an internal bank-select register loaded from schwapReg.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset (clears bank select and all registers)
//   write      - write enable for the active bank
//   writeAddr  - register index written when write=1
//   writeData  - data written
//   readAddrA  - read port A register index
//   readAddrB  - read port B register index
//   readDataA  - active bank[readAddrA], combinational
//   readDataB  - active bank[readAddrB], combinational
//   schwapReg  - bank number loaded on schwapEn
//   schwapEn   - bank-select load strobe
//   activeBank - current bank-select register value
module schwap_regfile #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned BANK_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddrA,
    input  logic [ADDR_WIDTH-1:0] readAddrB,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB,
    input  logic [BANK_BITS-1:0]  schwapReg,
    input  logic                  schwapEn,
    output logic [BANK_BITS-1:0]  activeBank
);

    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BANKS = 1 << BANK_BITS;

    logic [DATA_WIDTH-1:0] regs_q [NUM_BANKS][NUM_REGS];
    logic [BANK_BITS-1:0]  active_bank_q;
    logic [BANK_BITS-1:0]  active_bank_d;

    // Bank-select next state: load on strobe, otherwise hold.
    always_comb begin
        active_bank_d = active_bank_q;
        if (schwapEn) begin
            active_bank_d = schwapReg;
        end
    end

    // State update. The write uses the pre-edge bank, so a write issued on the
    // same edge as a bank swap lands in the old bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_bank_q <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int r = 0; r < int'(NUM_REGS); r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            active_bank_q <= active_bank_d;
            if (write) begin
                regs_q[active_bank_q][writeAddr] <= writeData;
            end
        end
    end

    // Zero-latency reads from the active bank; no write-through bypass.
    assign readDataA  = regs_q[active_bank_q][readAddrA];
    assign readDataB  = regs_q[active_bank_q][readAddrB];
    assign activeBank = active_bank_q;

endmodule

// File: tb/tb_schwap_regfile.sv
// Directed self-checking bench for schwap_regfile.
module tb_schwap_regfile;

    logic        clk;
    logic        reset;
    logic        write;
    logic [1:0]  writeAddr;
    logic [15:0] writeData;
    logic [1:0]  readAddrA;
    logic [1:0]  readAddrB;
    logic [15:0] readDataA;
    logic [15:0] readDataB;
    logic [3:0]  schwapReg;
    logic        schwapEn;
    logic [3:0]  activeBank;

    int unsigned n_checks;
    int unsigned n_errors;

    schwap_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .writeAddr  (writeAddr),
        .writeData  (writeData),
        .readAddrA  (readAddrA),
        .readAddrB  (readAddrB),
        .readDataA  (readDataA),
        .readDataB  (readDataB),
        .schwapReg  (schwapReg),
        .schwapEn   (schwapEn),
        .activeBank (activeBank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so reads are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select_bank(input int b);
        schwapReg = 4'(b);
        schwapEn  = 1'b1;
        tick();
        schwapEn  = 1'b0;
    endtask

    task automatic write_reg(input int a, input logic [15:0] d);
        writeAddr = 2'(a);
        writeData = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic read_both(input string tag, input int a, input logic [15:0] exp);
        readAddrA = 2'(a);
        readAddrB = 2'(a);
        #1;
        check({tag, "_A"}, readDataA, exp);
        check({tag, "_B"}, readDataB, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        write     = 1'b0;
        writeAddr = '0;
        writeData = '0;
        readAddrA = '0;
        readAddrB = '0;
        schwapReg = '0;
        schwapEn  = 1'b0;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_bank", 16'(activeBank), 16'h0000);
        read_both("rst_r0", 0, 16'h0000);
        read_both("rst_r3", 3, 16'h0000);

        // Fill every bank with (bank<<4)|reg
        for (int i = 0; i < 16; i++) begin
            select_bank(i);
            for (int j = 0; j < 4; j++) begin
                write_reg(j, 16'((i << 4) | j));
            end
        end

        // Read back every bank
        for (int i = 0; i < 16; i++) begin
            select_bank(i);
            check("fill_bank", 16'(activeBank), 16'(i));
            for (int j = 0; j < 4; j++) begin
                read_both("fill_rd", j, 16'((i << 4) | j));
            end
        end

        // Isolation between banks
        do_reset();
        select_bank(3);
        write_reg(1, 16'hA5A5);
        read_both("iso_b3_wr", 1, 16'hA5A5);
        select_bank(4);
        read_both("iso_b4", 1, 16'h0000);
        select_bank(3);
        read_both("iso_b3", 1, 16'hA5A5);
        read_both("iso_b3_r0", 0, 16'h0000);

        // Dual independent read ports
        select_bank(7);
        write_reg(0, 16'h1111);
        write_reg(1, 16'h2222);
        write_reg(2, 16'h3333);
        write_reg(3, 16'h4444);
        readAddrA = 2'd0;
        readAddrB = 2'd3;
        #1;
        check("dual_A0", readDataA, 16'h1111);
        check("dual_B3", readDataB, 16'h4444);
        readAddrA = 2'd1;
        readAddrB = 2'd2;
        #1;
        check("dual_A1", readDataA, 16'h2222);
        check("dual_B2", readDataB, 16'h3333);
        read_both("dual_same2", 2, 16'h3333);

        // Swap and write on the same edge: write lands in the old bank
        select_bank(5);
        schwapReg = 4'd6;
        schwapEn  = 1'b1;
        writeAddr = 2'd0;
        writeData = 16'hBEEF;
        write     = 1'b1;
        tick();
        schwapEn  = 1'b0;
        write     = 1'b0;
        check("sw_bank", 16'(activeBank), 16'h0006);
        read_both("sw_b6", 0, 16'h0000);
        select_bank(5);
        read_both("sw_b5", 0, 16'hBEEF);

        // write=0 with varying address/data changes nothing
        select_bank(7);
        write     = 1'b0;
        writeData = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            writeAddr = 2'(k);
            tick();
        end
        read_both("wd_r0", 0, 16'h1111);
        read_both("wd_r1", 1, 16'h2222);
        read_both("wd_r2", 2, 16'h3333);
        read_both("wd_r3", 3, 16'h4444);

        // Read during write: old value before the edge, new value after
        readAddrA = 2'd2;
        writeAddr = 2'd2;
        writeData = 16'h5A5A;
        write     = 1'b1;
        #1;
        check("rdw_before", readDataA, 16'h3333);
        tick();
        write = 1'b0;
        check("rdw_after", readDataA, 16'h5A5A);

        // Reset mid-operation discards concurrent write and swap
        select_bank(0);
        write_reg(0, 16'h0101);
        select_bank(7);
        schwapReg = 4'd9;
        schwapEn  = 1'b1;
        writeAddr = 2'd1;
        writeData = 16'hDEAD;
        write     = 1'b1;
        reset     = 1'b1;
        tick();
        reset    = 1'b0;
        write    = 1'b0;
        schwapEn = 1'b0;
        check("mrst_bank", 16'(activeBank), 16'h0000);
        for (int i = 0; i < 16; i++) begin
            select_bank(i);
            for (int j = 0; j < 4; j++) begin
                read_both("mrst_rd", j, 16'h0000);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/schwap_regfile.md
Name: schwap_regfile

Overview:
- Banked ("schwap") register file: 16 banks, each holding 4 registers of 16 bits.
- Two combinational read ports and one synchronous write port, all addressing the currently active bank.
- The active bank is held in an internal bank-select register, loaded from schwapReg on a strobe.
- Used as the CPU general register file; register-window swap happens without copying data.

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 2, register address bits per bank (4 registers).
- BANK_BITS, 4, bank-select bits (16 banks).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  write enable for the active bank.
- writeAddr  input  ADDR_WIDTH  register written when write=1.
- writeData  input  DATA_WIDTH  data written.
- readAddrA  input  ADDR_WIDTH  read port A address.
- readAddrB  input  ADDR_WIDTH  read port B address.
- readDataA  output  DATA_WIDTH  contents of active bank[readAddrA].
- readDataB  output  DATA_WIDTH  contents of active bank[readAddrB].
- schwapReg  input  BANK_BITS  bank number to select.
- schwapEn  input  1  bank-select load strobe, sampled on clk.
- activeBank  output  BANK_BITS  current bank-select register value.

Behaviour:
- Single clock domain: clk only. Reset is synchronous, active-high.
- Reset, at a rising clk edge with reset=1:
  - activeBank <= 0.
  - All 64 registers <= 0.
  - write and schwapEn are ignored that cycle.
  - readDataA/B therefore read 0 after the edge.
- Bank select: on a rising edge with schwapEn=1, activeBank <= schwapReg. Otherwise it holds. Range 0..15, no wrap logic needed.
- Write: on a rising edge with write=1, bank[activeBank][writeAddr] <= writeData.
  - The bank used is the pre-edge activeBank.
  - No other register changes.
- Reads: purely combinational from bank[activeBank][readAddrX]; zero-cycle latency.
  - Ports A and B are independent; the same address on both returns identical data.
- Simultaneous schwapEn and write in one cycle: the write lands in the old bank. The new bank is active for reads after the edge and for writes from the next edge.
- Read during write to the same address: the old value is visible until the edge, the new value immediately after. There is no write-through bypass.
- Bank switch latency: readData reflects the new bank immediately after the loading edge.
- Banks are fully isolated: a write never alters any other bank.
- write=0 with arbitrary writeAddr/writeData: no state change.
- No X propagation: all state is defined after the first reset.

Test Plan:
- Fill and read back:
  - Reset, then for each bank i=0..15: pulse schwapEn with schwapReg=i, then write value (i<<4)|j to reg j=0..3.
  - Re-select each bank: readDataA/B at addr j = (i<<4)|j, and activeBank=i.
- Isolation:
  - Bank 3, reg 1 <= 0xA5A5; select bank 4.
  - Reg 1 reads 0x0000 on both ports.
  - Reselect bank 3: reg 1 reads 0xA5A5.
- Dual read:
  - In one bank write regs 0..3 = 0x1111, 0x2222, 0x3333, 0x4444.
  - readAddrA=0, readAddrB=3 -> 0x1111 / 0x4444.
  - A=B=2 -> 0x3333 on both.
- Simultaneous swap and write:
  - activeBank=5; same edge: schwapEn=1, schwapReg=6, write=1, writeAddr=0, writeData=0xBEEF.
  - Bank 5 reg 0 = 0xBEEF; bank 6 reg 0 unchanged (0); activeBank=6.
- Write disabled and read timing:
  - write=0 with writeData=0xFFFF for several edges: no register changes.
  - With write=1 to reg 2: readDataA at addr 2 shows the old value before the edge and the new value after.
- Reset mid-operation:
  - After filling banks, assert reset for one edge while write=1 and schwapEn=1.
  - activeBank=0 and all banks read 0x0000; the concurrent write is discarded.
